// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle for the bit-serial adder controller
interface serial_add_ctrl_if #(
  parameter int W = 8
);
  logic         start;
  logic         abort;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         add_en;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, abort, a_in, b_in, cin,
    input  busy, add_en, done, sum, cout
  );

  modport slave (
    input  start, abort, a_in, b_in, cin,
    output busy, add_en, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder: one full-adder slice iterated W times
module serial_add_ctrl #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                reset,
  serial_add_ctrl_if.slave    bus
);

  localparam int             CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0]  LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [W-1:0]  a_sh_q;
  logic [W-1:0]  b_sh_q;
  logic [W-1:0]  psum_q;
  logic [W-1:0]  sum_q;
  logic [CW-1:0] cnt_q;
  logic          carry_q;
  logic          cout_q;
  logic          busy_q;
  logic          add_en_q;
  logic          done_q;

  logic          s_d;
  logic          c_d;
  logic [W-1:0]  psum_d;

  // The single full-adder slice; LSBs are consumed first, sum bits enter at the MSB.
  always_comb begin
    s_d    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    c_d    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    psum_d = {s_d, psum_q[W-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      psum_q   <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      add_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          // abort has no meaning here, so a simultaneous start simply proceeds
          if (bus.start) begin
            a_sh_q   <= bus.a_in;
            b_sh_q   <= bus.b_in;
            carry_q  <= bus.cin;
            psum_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            add_en_q <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            busy_q   <= 1'b0;
            add_en_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            psum_q  <= psum_d;
            a_sh_q  <= {1'b0, a_sh_q[W-1:1]};
            b_sh_q  <= {1'b0, b_sh_q[W-1:1]};
            carry_q <= c_d;
            if (cnt_q == LAST) begin
              sum_q    <= psum_d;
              cout_q   <= c_d;
              busy_q   <= 1'b0;
              add_en_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q   <= 1'b0;
          add_en_q <= 1'b0;
          done_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.add_en = add_en_q;
  assign bus.done   = done_q;
  assign bus.sum    = sum_q;
  assign bus.cout   = cout_q;

endmodule
